mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. Holds the EX→MEM pipeline register, consumes the data-SRAM read data returned one cycle after EX issued the request, and aligns and sign/zero-extends load data. Produces the MEM→WB bus and an identical forwarding bus to ID. Buffers the SRAM read data so a load survives any number of stall cycles.

## Interface
Parameters: none. Widths come from `lib/defines.vh`:
- `EX_TO_MEM_WD` = 80
- `MEM_TO_WB_WD` = 70
- `StallBus` = 6
- `Stop` = 1'b1, `NoStop` = 1'b0

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  `StallBus`  pipeline stall vector; this stage uses stall[3] (own input register) and stall[4] (downstream).
- ex_to_mem_bus  input  `EX_TO_MEM_WD`  fields, MSB first:
  - ld_op[79:76], one-hot: [0] LB, [1] LBU, [2] LH, [3] LHU
  - ex_pc[75:44]
  - data_ram_en[43]
  - data_ram_wen[42:39]
  - sel_rf_res[38]
  - rf_we[37]
  - rf_waddr[36:32]
  - ex_result[31:0], the ALU result or memory address
- data_sram_rdata  input  32  SRAM read data, valid in the first cycle an instruction occupies MEM.
- mem_to_wb_bus  output  `MEM_TO_WB_WD`  fields: mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0].
- mem_to_id_bus  output  `MEM_TO_WB_WD`  bit-identical copy of mem_to_wb_bus, used for forwarding.

## Operation
Pipeline register `r`, priority order:
- rst → r = 0.
- stall[3]==Stop and stall[4]==NoStop → r = 0 (bubble).
- stall[3]==NoStop → r = ex_to_mem_bus.
- Otherwise → hold.

A load is `is_load = data_ram_en & (data_ram_wen==4'b0) & sel_rf_res`. A store (wen≠0) writes nothing here, and its rf_we is passed through as given.

Read-data buffer (`rdata_buf[31:0]`, `buf_valid`):
- On the edge where r loads, or becomes a bubble, or on rst: buf_valid ← 0.
- Otherwise, if is_load and !buf_valid: rdata_buf ← data_sram_rdata and buf_valid ← 1 (captures the first MEM cycle).
- Otherwise: hold.
- Effective data: `rd = buf_valid ? rdata_buf : data_sram_rdata`.

Alignment uses `a = ex_result[1:0]`:
- byte = rd[8a+7 : 8a].
- half = a[1] ? rd[31:16] : rd[15:0]; a[0] is ignored, no misalign trap.
- LB: sign-extend byte. LBU: zero-extend byte.
- LH: sign-extend half. LHU: zero-extend half.
- ld_op==0: word (rd).
- ld_op with more than one bit set: unsupported, result undefined.

Write data:
- rf_wdata = is_load ? aligned load data : ex_result.
- Output fields mem_pc, rf_we and rf_waddr come directly from r.

## Timing
- Reset: r=0, buf_valid=0, rdata_buf=0. Both output buses read all-zero (rf_we=0), because rf_wdata of a zero register is ex_result=0.
- Latency: one cycle from ex_to_mem_bus to the outputs. The outputs are combinational from r, rd and rdata_buf, so there is no extra register.
- SRAM contract: rdata is valid only in the first cycle after EX asserted data_sram_en. From the second held cycle onward the output must come from rdata_buf, and must stay unchanged even if data_sram_rdata changes.
- Bubble and load in the same edge are impossible by the priority order. A bubble clears buf_valid.
- Reset asserted mid-stall clears r and the buffer on that edge. The next cycle outputs zero.
- Back-to-back loads, with no stall: the buffer is re-armed every edge and rd always equals live rdata.
- mem_to_id_bus must equal mem_to_wb_bus in every cycle.

## Test plan
- Reset: hold rst 2 cycles with random inputs → both buses == 70'h0 and rf_we=0, checked in the cycle after release.
- ALU passthrough: bus with pc=0xBFC0_0010, rf_we=1, waddr=5, ex_result=0x1234_5678, ram_en=0 → next cycle wb bus = {0xBFC00010, 1, 5, 0x12345678}.
- Byte loads: rdata=0x80FF_7F01.
  - LB addr …3 → 0xFFFF_FF80.
  - LBU addr …3 → 0x0000_0080.
  - LB addr …1 → 0x0000_007F.
  - LH addr …2 → 0xFFFF_80FF.
  - LHU addr …0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Stall hold: LW enters MEM with rdata=0xDEAD_BEEF, then stall[4:3]=11 for 3 cycles while rdata changes to 0x0 → rf_wdata stays 0xDEAD_BEEF all 4 cycles.
- Bubble: stall[3]=1 with stall[4]=0 → the next cycle's bus is all-zero and buf_valid=0. A following LW with rdata=0x1 → rf_wdata=0x1.
- Reset mid-stall: during the held LW, assert rst for 1 cycle → outputs zero next cycle. A new LW with rdata=0xA5A5_A5A5 → 0xA5A5_A5A5, not stale data.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : EX->MEM pipeline register, SRAM read-data buffering, load data
//            alignment/extension; drives the MEM->WB and MEM->ID buses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [79:0] ex_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] mem_to_wb_bus,
    output logic [69:0] mem_to_id_bus
);

    localparam logic c_STOP    = 1'b1;
    localparam logic c_NO_STOP = 1'b0;

    logic [79:0] r_ex_mem;
    logic [31:0] r_rdata_buf;
    logic        r_buf_valid;

    logic [3:0]  w_ld_op;
    logic [31:0] w_pc;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_sel_rf_res;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_ex_result;
    logic        w_is_load;
    logic        w_bubble;
    logic        w_advance;
    logic [1:0]  w_addr_lo;
    logic [31:0] w_rd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;

    assign w_bubble  = (stall[3] == c_STOP) && (stall[4] == c_NO_STOP);
    assign w_advance = (stall[3] == c_NO_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_mem <= '0;
        end else if (w_bubble) begin
            r_ex_mem <= '0;
        end else if (w_advance) begin
            r_ex_mem <= ex_to_mem_bus;
        end
    end

    assign w_ld_op      = r_ex_mem[79:76];
    assign w_pc         = r_ex_mem[75:44];
    assign w_ram_en     = r_ex_mem[43];
    assign w_ram_wen    = r_ex_mem[42:39];
    assign w_sel_rf_res = r_ex_mem[38];
    assign w_rf_we      = r_ex_mem[37];
    assign w_rf_waddr   = r_ex_mem[36:32];
    assign w_ex_result  = r_ex_mem[31:0];

    assign w_is_load = w_ram_en && (w_ram_wen == 4'b0000) && w_sel_rf_res;

    // SRAM data is only valid in the first MEM cycle; keep it for held loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_buf <= '0;
            r_buf_valid <= 1'b0;
        end else if (w_bubble || w_advance) begin
            r_buf_valid <= 1'b0;
        end else if (w_is_load && !r_buf_valid) begin
            r_rdata_buf <= data_sram_rdata;
            r_buf_valid <= 1'b1;
        end
    end

    assign w_rd      = r_buf_valid ? r_rdata_buf : data_sram_rdata;
    assign w_addr_lo = w_ex_result[1:0];
    assign w_half    = w_addr_lo[1] ? w_rd[31:16] : w_rd[15:0];

    always_comb begin
        w_byte = w_rd[7:0];
        case (w_addr_lo)
            2'd0:    w_byte = w_rd[7:0];
            2'd1:    w_byte = w_rd[15:8];
            2'd2:    w_byte = w_rd[23:16];
            default: w_byte = w_rd[31:24];
        endcase
    end

    always_comb begin
        w_load_data = w_rd;
        if (w_ld_op[0]) begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (w_ld_op[1]) begin
            w_load_data = {24'd0, w_byte};
        end else if (w_ld_op[2]) begin
            w_load_data = {{16{w_half[15]}}, w_half};
        end else if (w_ld_op[3]) begin
            w_load_data = {16'd0, w_half};
        end
    end

    assign w_rf_wdata    = w_is_load ? w_load_data : w_ex_result;
    assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_to_id_bus = mem_to_wb_bus;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage with directed per-cycle vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [79:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [69:0] mem_to_id_bus;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          chk;
        logic [69:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] c_RUN    = 6'b000000;
    localparam logic [5:0] c_HOLD   = 6'b011000;
    localparam logic [5:0] c_BUBBLE = 6'b001000;

    function automatic logic [79:0] mk(input logic [3:0] op, input logic [31:0] pc,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                       input logic [4:0] wa, input logic [31:0] d);
        return {pc, we, wa, d};
    endfunction

    function automatic logic [79:0] ld(input logic [3:0] op, input logic [31:0] pc,
                                       input logic [4:0] wa, input logic [31:0] addr);
        return mk(op, pc, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
    endfunction

    // One clock cycle: inputs for this cycle plus the outputs expected during it.
    task automatic cyc(input logic r, input logic [5:0] st, input logic [79:0] bus,
                       input logic [31:0] rd, input bit chk, input logic [69:0] exp,
                       input string name);
        sb_t e;
        @(posedge clk);
        #1;
        rst             = r;
        stall           = st;
        ex_to_mem_bus   = bus;
        data_sram_rdata = rd;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk) begin
                checks++;
                if (mem_to_wb_bus !== e.exp) begin
                    errors++;
                    $display("FAIL %s: wb_bus got %h expected %h", e.name, mem_to_wb_bus, e.exp);
                end
                checks++;
                if (mem_to_id_bus !== e.exp) begin
                    errors++;
                    $display("FAIL %s_id: id_bus got %h expected %h", e.name, mem_to_id_bus, e.exp);
                end
            end
        end
    end

    localparam logic [31:0] c_BYTES = 32'h80FF_7F01;

    initial begin
        rst             = 1'b1;
        stall           = c_RUN;
        ex_to_mem_bus   = '0;
        data_sram_rdata = '0;

        cyc(1, c_RUN, {$urandom, $urandom, 16'($urandom)}, $urandom, 0, '0, "rst0");
        cyc(1, c_RUN, {$urandom, $urandom, 16'($urandom)}, $urandom, 0, '0, "rst1");
        cyc(0, c_RUN, '0, $urandom, 1, '0, "reset_state");

        cyc(0, c_RUN, mk(4'h0, 32'hBFC0_0010, 0, 4'h0, 0, 1, 5'd5, 32'h1234_5678),
            32'hFFFF_FFFF, 1, '0, "pre_alu");
        cyc(0, c_RUN, ld(4'b0001, 32'h100, 5'd1, 32'h1003), 32'hFFFF_FFFF, 1,
            wb(32'hBFC0_0010, 1, 5'd5, 32'h1234_5678), "alu_pass");

        cyc(0, c_RUN, ld(4'b0010, 32'h104, 5'd2, 32'h1003), c_BYTES, 1,
            wb(32'h100, 1, 5'd1, 32'hFFFF_FF80), "lb_a3");
        cyc(0, c_RUN, ld(4'b0001, 32'h108, 5'd3, 32'h1001), c_BYTES, 1,
            wb(32'h104, 1, 5'd2, 32'h0000_0080), "lbu_a3");
        cyc(0, c_RUN, ld(4'b0100, 32'h10C, 5'd4, 32'h1002), c_BYTES, 1,
            wb(32'h108, 1, 5'd3, 32'h0000_007F), "lb_a1");
        cyc(0, c_RUN, ld(4'b1000, 32'h110, 5'd6, 32'h1000), c_BYTES, 1,
            wb(32'h10C, 1, 5'd4, 32'hFFFF_80FF), "lh_a2");
        cyc(0, c_RUN, ld(4'b0000, 32'h114, 5'd7, 32'h1000), c_BYTES, 1,
            wb(32'h110, 1, 5'd6, 32'h0000_7F01), "lhu_a0");
        cyc(0, c_RUN, mk(4'h0, 32'h118, 1, 4'hF, 0, 0, 5'd0, 32'h2000), c_BYTES, 1,
            wb(32'h114, 1, 5'd7, 32'h80FF_7F01), "lw");
        cyc(0, c_RUN, ld(4'b0000, 32'h200, 5'd8, 32'h3000), c_BYTES, 1,
            wb(32'h118, 0, 5'd0, 32'h2000), "store_pass");

        cyc(0, c_HOLD, '0, 32'hDEAD_BEEF, 1, wb(32'h200, 1, 5'd8, 32'hDEAD_BEEF), "hold0");
        cyc(0, c_HOLD, '0, 32'h0, 1, wb(32'h200, 1, 5'd8, 32'hDEAD_BEEF), "hold1");
        cyc(0, c_HOLD, '0, 32'h0, 1, wb(32'h200, 1, 5'd8, 32'hDEAD_BEEF), "hold2");
        cyc(0, c_RUN, '0, 32'h0, 1, wb(32'h200, 1, 5'd8, 32'hDEAD_BEEF), "hold3");

        cyc(0, c_BUBBLE, ld(4'b0000, 32'h300, 5'd9, 32'h4000), 32'h5555_5555, 1, '0, "pre_bubble");
        cyc(0, c_RUN, ld(4'b0000, 32'h304, 5'd10, 32'h4004), 32'h5555_5555, 1, '0, "bubble");
        cyc(0, c_RUN, '0, 32'h0000_0001, 1, wb(32'h304, 1, 5'd10, 32'h1), "post_bubble_lw");

        cyc(0, c_RUN, ld(4'b0000, 32'h400, 5'd11, 32'h5000), 32'h7777_7777, 1, '0, "pre_rst");
        cyc(0, c_HOLD, '0, 32'h1111_2222, 1, wb(32'h400, 1, 5'd11, 32'h1111_2222), "rst_hold0");
        cyc(1, c_HOLD, '0, 32'h0, 1, wb(32'h400, 1, 5'd11, 32'h1111_2222), "rst_hold1");
        cyc(0, c_RUN, ld(4'b0000, 32'h404, 5'd12, 32'h5004), 32'hFFFF_FFFF, 1, '0, "after_rst");
        cyc(0, c_RUN, '0, 32'hA5A5_A5A5, 1, wb(32'h404, 1, 5'd12, 32'hA5A5_A5A5), "fresh_lw");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
